// File: rtl/fetch_unit_if.sv
// Instruction memory read bus between fetch_unit (master) and instruction memory (slave).
// Optional feature macro: FETCH_ABORT_EN adds mem_abort, qualified by mem_ack.
interface fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef FETCH_ABORT_EN
    logic        mem_abort;

    modport master (output mem_req, output mem_addr,
                    input  mem_ack, input  mem_rdata, input  mem_abort);
    modport slave  (input  mem_req, input  mem_addr,
                    output mem_ack, output mem_rdata, output mem_abort);
`else
    modport master (output mem_req, output mem_addr,
                    input  mem_ack, input  mem_rdata);
    modport slave  (input  mem_req, input  mem_addr,
                    output mem_ack, output mem_rdata);
`endif
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding word read at a time,
// buffers fetched words in a small prefetch FIFO and presents the head to decode.
// branch_taken flushes the FIFO and redirects; an unacked request is drained first.
// Optional feature macro: FETCH_ABORT_EN adds a per-entry abort bit (mem_abort -> instr_abort).
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                clk1,
    input  logic                rst,
    fetch_unit_if.master        mem,
    input  logic                branch_taken,
    input  logic [31:0]         branch_target,
    output logic                instr_valid,
    output logic [31:0]         instr,
    output logic [31:0]         instr_pc,
    output logic [31:0]         pc_plus8,
    input  logic                instr_ready
`ifdef FETCH_ABORT_EN
    ,
    output logic                instr_abort
`endif
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

    state_e            state_q, state_d;
    logic [31:0]       fetch_pc_q;
    logic [31:0]       drain_addr_q;
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic [31:0]       pc_mem_q   [FIFO_DEPTH];
    logic [31:0]       data_mem_q [FIFO_DEPTH];
`ifdef FETCH_ABORT_EN
    logic              abort_mem_q [FIFO_DEPTH];
`endif

    logic              pop;
    logic              push;
    logic [CntW-1:0]   count_after_pop;
    logic [CntW-1:0]   count_after_push;
    logic              unused_target_lsbs;

    // Target is forced word-aligned; the low bits are intentionally dropped.
    assign unused_target_lsbs = ^branch_target[1:0];

    assign pop              = instr_valid && instr_ready;
    // Ack data arriving with a branch belongs to the old stream and is dropped.
    assign push             = (state_q == StReq) && mem.mem_ack && !branch_taken;
    assign count_after_pop  = count_q - CntW'(pop);
    assign count_after_push = count_after_pop + CntW'(push);

    // State register.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: branch has priority; a request in flight must be drained before redirect.
    always_comb begin
        state_d = state_q;
        if (branch_taken) begin
            unique case (state_q)
                StReq:   state_d = mem.mem_ack ? StReq : StDrain;
                StDrain: state_d = mem.mem_ack ? StReq : StDrain;
                default: state_d = StReq;
            endcase
        end else begin
            unique case (state_q)
                StIdle:  state_d = (count_after_pop < CntW'(FIFO_DEPTH)) ? StReq : StIdle;
                StReq: begin
                    if (mem.mem_ack) begin
                        state_d = (count_after_push < CntW'(FIFO_DEPTH)) ? StReq : StIdle;
                    end
                end
                StDrain: state_d = mem.mem_ack ? StReq : StDrain;
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs: bus request from state, decode-side view from the FIFO head.
    always_comb begin
        mem.mem_req  = (state_q != StIdle);
        mem.mem_addr = (state_q == StDrain) ? drain_addr_q : fetch_pc_q;
        instr_valid  = (count_q != '0);
        instr        = instr_valid ? data_mem_q[rd_ptr_q] : 32'h0;
        instr_pc     = instr_valid ? pc_mem_q[rd_ptr_q] : 32'h0;
        pc_plus8     = instr_valid ? (pc_mem_q[rd_ptr_q] + 32'd8) : 32'h0;
`ifdef FETCH_ABORT_EN
        instr_abort  = instr_valid && abort_mem_q[rd_ptr_q];
`endif
    end

    // Fetch PC, drain address and FIFO pointers/occupancy.
    always_ff @(posedge clk1) begin
        if (rst) begin
            fetch_pc_q   <= RESET_PC & ~32'h3;
            drain_addr_q <= 32'h0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else if (branch_taken) begin
            fetch_pc_q <= {branch_target[31:2], 2'b00};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            // Drain keeps presenting the address of the abandoned request.
            if (state_q == StReq) begin
                drain_addr_q <= fetch_pc_q;
            end
        end else begin
            if (push) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
                wr_ptr_q   <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_after_push;
        end
    end

    // FIFO storage; contents are only observed through valid-qualified outputs.
    always_ff @(posedge clk1) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            data_mem_q[wr_ptr_q]  <= mem.mem_rdata;
`ifdef FETCH_ABORT_EN
            abort_mem_q[wr_ptr_q] <= mem.mem_abort;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, backpressure, branch drain/flush,
// PC wrap and reset mid-request. Memory returns ~addr as the instruction word.
module tb_fetch_unit;

    logic        clk1 = 1'b0;
    logic        rst  = 1'b1;
    logic        branch_taken  = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus8;
    logic        instr_ready = 1'b1;
`ifdef FETCH_ABORT_EN
    logic        instr_abort;
`endif

    fetch_unit_if mif ();

    fetch_unit #(
        .RESET_PC   (32'h0000_0100),
        .FIFO_DEPTH (2)
    ) dut (
        .clk1          (clk1),
        .rst           (rst),
        .mem           (mif),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .pc_plus8      (pc_plus8),
        .instr_ready   (instr_ready)
`ifdef FETCH_ABORT_EN
        ,
        .instr_abort   (instr_abort)
`endif
    );

    always #5 clk1 = ~clk1;

    int          n_checks = 0;
    int          n_errors = 0;
    int          lat      = 1;
    int          cnt      = 0;
    bit          mem_en   = 1'b1;
    bit          stray    = 1'b0;
    int          ack_cnt;
    logic [31:0] exp_pc;
    logic [31:0] abort_addr = 32'h0000_0104;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk1);
    endtask

    // Memory model: decides the ack for the coming edge just after each falling edge.
    initial begin
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 32'h0;
`ifdef FETCH_ABORT_EN
        mif.mem_abort = 1'b0;
`endif
        forever begin
            @(negedge clk1);
            #1;
            if (stray) begin
                mif.mem_ack   = 1'b1;
                mif.mem_rdata = 32'hDEAD_BEEF;
`ifdef FETCH_ABORT_EN
                mif.mem_abort = 1'b1;
`endif
                cnt = 0;
            end else if (mif.mem_req && mem_en && cnt >= lat) begin
                mif.mem_ack   = 1'b1;
                mif.mem_rdata = ~mif.mem_addr;
`ifdef FETCH_ABORT_EN
                mif.mem_abort = (mif.mem_addr == abort_addr);
`endif
                cnt = 0;
            end else begin
                mif.mem_ack   = 1'b0;
                mif.mem_rdata = 32'h0;
`ifdef FETCH_ABORT_EN
                mif.mem_abort = 1'b0;
`endif
                if (mif.mem_req) cnt++;
                else cnt = 0;
            end
        end
    end

    // Completed memory transactions since the last reset.
    always @(posedge clk1) begin
        if (rst) ack_cnt <= 0;
        else if (mif.mem_req && mif.mem_ack) ack_cnt <= ack_cnt + 1;
    end

    // Samples the current edge first, then advances; expects n in-order words from exp_pc.
    task automatic consume(input string tag, input int n, input int budget);
        int got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            if (instr_valid && instr_ready) begin
                check({tag, "_pc"}, instr_pc, exp_pc);
                check({tag, "_instr"}, instr, ~exp_pc);
                check({tag, "_pc8"}, pc_plus8, exp_pc + 32'd8);
`ifdef FETCH_ABORT_EN
                check({tag, "_abort"}, {31'h0, instr_abort}, {31'h0, exp_pc == abort_addr});
`endif
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            tick();
        end
        check({tag, "_count"}, got, n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // 1: reset values, then sequential fetch with 1-cycle ack latency.
        tick();
        tick();
        check("rst_req", {31'h0, mif.mem_req}, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_pc8", pc_plus8, 32'h0);
        check("rst_addr", mif.mem_addr, 32'h0000_0100);
        rst    = 1'b0;
        exp_pc = 32'h0000_0100;
        consume("t1", 3, 40);
        // Zero-wait memory: one instruction per cycle once steady.
        lat = 0;
        consume("t1_warm", 3, 15);
        consume("t1_rate", 4, 4);

        // 2: decode stalled -> exactly FIFO_DEPTH fetches, then resume without loss.
        lat         = 1;
        instr_ready = 1'b0;
        do_reset();
        repeat (12) tick();
        check("t2_acks", ack_cnt, 2);
        check("t2_req", {31'h0, mif.mem_req}, 32'h0);
        check("t2_addr", mif.mem_addr, 32'h0000_0108);
        check("t2_pc", instr_pc, 32'h0000_0100);
        repeat (3) tick();
        check("t2_hold_pc", instr_pc, 32'h0000_0100);
        check("t2_hold_instr", instr, ~32'h0000_0100);
        instr_ready = 1'b1;
        exp_pc      = 32'h0000_0100;
        consume("t2", 4, 30);

        // 3: branch while a request is unacked -> drain, old data discarded.
        mem_en = 1'b0;
        do_reset();
        tick();
        tick();
        check("t3_req", {31'h0, mif.mem_req}, 32'h1);
        check("t3_addr", mif.mem_addr, 32'h0000_0100);
        branch_taken  = 1'b1;
        branch_target = 32'h0000_2003;
        tick();
        branch_taken = 1'b0;
        check("t3_drain_req", {31'h0, mif.mem_req}, 32'h1);
        check("t3_drain_addr", mif.mem_addr, 32'h0000_0100);
        mem_en = 1'b1;
        tick();
        check("t3_new_addr", mif.mem_addr, 32'h0000_2000);
        check("t3_valid", {31'h0, instr_valid}, 32'h0);
        exp_pc = 32'h0000_2000;
        consume("t3", 2, 30);

        // 4: branch coinciding with ack and pop -> ack dropped, head invalid next cycle.
        lat = 0;
        consume("t4_warm", 3, 20);
        check("t4_pre_valid", {31'h0, instr_valid}, 32'h1);
        branch_taken  = 1'b1;
        branch_target = 32'h0000_3000;
        tick();
        branch_taken = 1'b0;
        check("t4_valid", {31'h0, instr_valid}, 32'h0);
        check("t4_addr", mif.mem_addr, 32'h0000_3000);
        exp_pc = 32'h0000_3000;
        consume("t4", 2, 20);

        // 5: PC and pc_plus8 wrap at 2^32.
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFF8;
        tick();
        branch_taken = 1'b0;
        exp_pc       = 32'hFFFF_FFF8;
        consume("t5", 3, 20);

        // 6: reset mid-request; a stray ack afterwards is ignored.
        lat = 3;
        do_reset();
        tick();
        tick();
        check("t6_req", {31'h0, mif.mem_req}, 32'h1);
        check("t6_acks", ack_cnt, 0);
        rst = 1'b1;
        tick();
        check("t6_rst_req", {31'h0, mif.mem_req}, 32'h0);
        check("t6_rst_valid", {31'h0, instr_valid}, 32'h0);
        stray = 1'b1;
        rst   = 1'b0;
        tick();
        stray = 1'b0;
        check("t6_stray_valid", {31'h0, instr_valid}, 32'h0);
        check("t6_addr", mif.mem_addr, 32'h0000_0100);
        exp_pc = 32'h0000_0100;
        consume("t6", 3, 60);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
